// File: rtl/ball_pkg.sv
// Shared types and constants for the ball colour-scan block: FSM states,
// RGB565 field positions and coordinate widths.
package ball_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int X_W = 9;
    localparam int Y_W = 4;

endpackage

// File: rtl/ball_scan_if.sv
// Bus between the scan engine and its controller / line buffer:
// control, buffer read port, colour window and scan results.
interface ball_scan_if #(
    parameter int ADDR_W = 12,
    parameter int SUM_W  = 24
) ();
    import ball_pkg::*;

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rdaddr;
    logic [15:0]       rddata;
    logic [4:0]        r_min, r_max;
    logic [5:0]        g_min, g_max;
    logic [4:0]        b_min, b_max;
    logic              busy;
    logic              result_valid;
    logic [SUM_W-1:0]  hit_count;
    logic [SUM_W-1:0]  sum_x;
    logic [SUM_W-1:0]  sum_y;
    logic [X_W-1:0]    x_min, x_max;
    logic [Y_W-1:0]    y_min, y_max;

    modport master (
        output start, abort, rddata, r_min, r_max, g_min, g_max, b_min, b_max,
        input  rdaddr, busy, result_valid, hit_count, sum_x, sum_y,
               x_min, x_max, y_min, y_max
    );

    modport slave (
        input  start, abort, rddata, r_min, r_max, g_min, g_max, b_min, b_max,
        output rdaddr, busy, result_valid, hit_count, sum_x, sum_y,
               x_min, x_max, y_min, y_max
    );

endinterface

// File: rtl/ball_pix_classify.sv
// Combinational RGB565 colour-window test; a window with min>max never hits.
module ball_pix_classify
    import ball_pkg::*;
(
    input  logic [15:0] rddata,
    input  logic [4:0]  r_min, r_max,
    input  logic [5:0]  g_min, g_max,
    input  logic [4:0]  b_min, b_max,
    output logic        hit
);

    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;

    assign r = rddata[R_MSB:R_LSB];
    assign g = rddata[G_MSB:G_LSB];
    assign b = rddata[B_MSB:B_LSB];

    assign hit = (r >= r_min) && (r <= r_max) &&
                 (g >= g_min) && (g <= g_max) &&
                 (b >= b_min) && (b <= b_max);

endmodule

// File: rtl/ball_scan.sv
// Scans the captured line buffer once per start pulse and accumulates hit count,
// coordinate sums and (with BALL_BBOX_EN defined) the bounding box of the hits.
module ball_scan
    import ball_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 1,
    parameter int LINE_W    = 320,
    parameter int NUM_LINES = 12,
    parameter int SUM_W     = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    ball_scan_if.slave  bus
);

    localparam int N     = LINE_W * NUM_LINES;
    localparam int CNT_W = $clog2(N + 1);

    function automatic logic [SUM_W-1:0] sat_add(logic [SUM_W-1:0] a, logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [X_W-1:0]   x, px;
    logic [Y_W-1:0]   y, py;
    logic [0:0]       vld_pipe;
    logic [SUM_W-1:0] acc_cnt, acc_sx, acc_sy;
    logic [SUM_W-1:0] cnt_nxt, sx_nxt, sy_nxt;
    logic             hit, hit_v;

    ball_pix_classify u_cls (
        .rddata (bus.rddata),
        .r_min  (bus.r_min), .r_max (bus.r_max),
        .g_min  (bus.g_min), .g_max (bus.g_max),
        .b_min  (bus.b_min), .b_max (bus.b_max),
        .hit    (hit)
    );

    // rddata belongs to the address issued last cycle, tagged by vld_pipe/px/py
    assign hit_v = vld_pipe[0] & hit;

    always_comb begin
        cnt_nxt = acc_cnt;
        sx_nxt  = acc_sx;
        sy_nxt  = acc_sy;
        if (hit_v) begin
            cnt_nxt = sat_add(acc_cnt, SUM_W'(1));
            sx_nxt  = sat_add(acc_sx, SUM_W'(px));
            sy_nxt  = sat_add(acc_sy, SUM_W'(py));
        end
    end

`ifdef BALL_BBOX_EN
    logic [X_W-1:0] bx_min, bx_max, bx_min_nxt, bx_max_nxt;
    logic [Y_W-1:0] by_min, by_max, by_min_nxt, by_max_nxt;

    always_comb begin
        bx_min_nxt = bx_min;
        bx_max_nxt = bx_max;
        by_min_nxt = by_min;
        by_max_nxt = by_max;
        if (hit_v) begin
            if (px < bx_min) bx_min_nxt = px;
            if (px > bx_max) bx_max_nxt = px;
            if (py < by_min) by_min_nxt = py;
            if (py > by_max) by_max_nxt = py;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_min    <= '1;
            bx_max    <= '0;
            by_min    <= '1;
            by_max    <= '0;
            bus.x_min <= '0;
            bus.x_max <= '0;
            bus.y_min <= '0;
            bus.y_max <= '0;
        end else if (!bus.abort) begin
            if (state == IDLE && bus.start) begin
                bx_min <= '1;
                bx_max <= '0;
                by_min <= '1;
                by_max <= '0;
            end else begin
                bx_min <= bx_min_nxt;
                bx_max <= bx_max_nxt;
                by_min <= by_min_nxt;
                by_max <= by_max_nxt;
            end
            // no hits: report an all-zero box rather than the init sentinels
            if (state == DRAIN) begin
                bus.x_min <= (cnt_nxt == '0) ? '0 : bx_min_nxt;
                bus.x_max <= (cnt_nxt == '0) ? '0 : bx_max_nxt;
                bus.y_min <= (cnt_nxt == '0) ? '0 : by_min_nxt;
                bus.y_max <= (cnt_nxt == '0) ? '0 : by_max_nxt;
            end
        end
    end
`else
    assign bus.x_min = '0;
    assign bus.x_max = '0;
    assign bus.y_min = '0;
    assign bus.y_max = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            x                <= '0;
            y                <= '0;
            px               <= '0;
            py               <= '0;
            vld_pipe         <= '0;
            acc_cnt          <= '0;
            acc_sx           <= '0;
            acc_sy           <= '0;
            bus.rdaddr       <= ADDR_W'(BASE_ADDR);
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.hit_count    <= '0;
            bus.sum_x        <= '0;
            bus.sum_y        <= '0;
        end else begin
            vld_pipe[0]      <= 1'b0;
            bus.result_valid <= 1'b0;
            acc_cnt          <= cnt_nxt;
            acc_sx           <= sx_nxt;
            acc_sy           <= sy_nxt;
            if (bus.abort) begin
                state      <= IDLE;
                bus.busy   <= 1'b0;
                bus.rdaddr <= ADDR_W'(BASE_ADDR);
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state      <= READ;
                        bus.busy   <= 1'b1;
                        bus.rdaddr <= ADDR_W'(BASE_ADDR);
                        cnt        <= '0;
                        x          <= '0;
                        y          <= '0;
                        acc_cnt    <= '0;
                        acc_sx     <= '0;
                        acc_sy     <= '0;
                    end
                    READ: begin
                        vld_pipe[0] <= 1'b1;
                        px          <= x;
                        py          <= y;
                        bus.rdaddr  <= bus.rdaddr + ADDR_W'(1);
                        cnt         <= cnt + CNT_W'(1);
                        if (x == X_W'(LINE_W - 1)) begin
                            x <= '0;
                            y <= y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                        if (cnt == CNT_W'(N - 1)) state <= DRAIN;
                    end
                    DRAIN: begin
                        state            <= DONE;
                        bus.busy         <= 1'b0;
                        bus.result_valid <= 1'b1;
                        bus.rdaddr       <= ADDR_W'(BASE_ADDR);
                        bus.hit_count    <= cnt_nxt;
                        bus.sum_x        <= sx_nxt;
                        bus.sum_y        <= sy_nxt;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
